// File: rtl/cpu_pkg.sv
// Shared CPU-side types and default widths.
// Used by the OAM DMA controller, control decoder and regfile.
package cpu_pkg;

   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_DATA_W     = 16;
   localparam int DEF_OAM_ADDR_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      LAST
   } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Data-memory port arbiter and OAM block-copy engine.
// CPU passes through when idle; engine streams one word per cycle when busy.
module oam_dma_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int OAM_ADDR_W = DEF_OAM_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dma_start,
   input  logic [ADDR_W-1:0]     dma_src,
   input  logic [OAM_ADDR_W:0]   dma_len,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic [DATA_W-1:0]     cpu_wdata,
   input  logic                  cpu_mem_read,
   input  logic                  cpu_mem_write,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [OAM_ADDR_W-1:0] oam_addr,
   output logic [DATA_W-1:0]     oam_wdata,
   output logic                  oam_we,
   output logic                  cpu_stall,
   output logic                  dma_busy,
   output logic                  dma_done
);

   localparam int CW = OAM_ADDR_W + 1;
   localparam logic [CW-1:0] MAX_LEN = CW'(2 ** OAM_ADDR_W);

   dma_state_t        state;
   logic [ADDR_W-1:0] src_q;
   logic [CW-1:0]     len_q;
   logic [CW-1:0]     rd_cnt;
   logic              done_q;
   logic [CW-1:0]     eff_len;

   assign eff_len = (dma_len > MAX_LEN) ? MAX_LEN : dma_len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         src_q  <= '0;
         len_q  <= '0;
         rd_cnt <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (dma_start && eff_len != '0) begin
                  src_q  <= dma_src;
                  len_q  <= eff_len;
                  rd_cnt <= '0;
                  state  <= XFER;
               end
            end
            XFER: begin
               rd_cnt <= rd_cnt + CW'(1);
               if (rd_cnt == len_q - CW'(1))
                  state <= LAST;
            end
            LAST: begin
               state  <= IDLE;
               done_q <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write side trails the read side by one word: OAM[rd_cnt-1] <= mem_rdata.
   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_re    = cpu_mem_read;
      mem_we    = cpu_mem_write;
      oam_we    = 1'b0;
      oam_addr  = '0;
      oam_wdata = '0;
      if (state != IDLE) begin
         mem_addr  = src_q + ADDR_W'(rd_cnt);
         mem_wdata = '0;
         mem_we    = 1'b0;
         mem_re    = (state == XFER);
         if (rd_cnt != '0) begin
            oam_we    = 1'b1;
            oam_addr  = OAM_ADDR_W'(rd_cnt - CW'(1));
            oam_wdata = mem_rdata;
         end
      end
   end

   assign dma_busy  = (state != IDLE);
   assign cpu_stall = dma_busy;
   assign dma_done  = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl with a 1-cycle data memory and OAM model.
// Expected values come from hand-set memory contents and a fixed pattern.
module tb_oam_dma_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dma_start = 1'b0;
   logic [15:0] dma_src = '0;
   logic [8:0]  dma_len = '0;
   logic [15:0] cpu_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic        cpu_mem_read = 1'b0;
   logic        cpu_mem_write = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic [7:0]  oam_addr;
   logic [15:0] oam_wdata;
   logic        oam_we;
   logic        cpu_stall;
   logic        dma_busy;
   logic        dma_done;

   oam_dma_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .dma_start(dma_start), .dma_src(dma_src), .dma_len(dma_len),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_re(mem_re), .mem_we(mem_we),
      .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
      .cpu_stall(cpu_stall), .dma_busy(dma_busy), .dma_done(dma_done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   function automatic logic [15:0] pat(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   logic [15:0] mem [0:65535];
   logic [15:0] oam [0:255];
   logic [15:0] rd_q [$];
   int cyc = 0, start_cyc = 0, done_cyc = 0;
   int stall_cnt = 0, owe_cnt = 0, done_cnt = 0, bad_cnt = 0;

   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
         mem[16'h0400] = 16'hAAAA;
         mem[16'h0401] = 16'hBBBB;
         mem[16'h0402] = 16'hCCCC;
         mem[16'h0403] = 16'hDDDD;
      end
      if (rst_n && dma_start && !dma_busy) start_cyc = cyc;
      if (cpu_stall) stall_cnt++;
      if (oam_we) begin
         owe_cnt++;
         oam[oam_addr] = oam_wdata;
      end
      if (dma_done) begin
         done_cnt++;
         done_cyc = cyc;
         if (cpu_stall) bad_cnt++;
      end
      if (mem_re && dma_busy) rd_q.push_back(mem_addr);
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] = mem_wdata;
      cyc++;
   end

   int s_stall, s_owe, s_done, s_rd;

   task automatic snap();
      s_stall = stall_cnt;
      s_owe   = owe_cnt;
      s_done  = done_cnt;
      s_rd    = rd_q.size();
   endtask

   task automatic start(input logic [15:0] s, input logic [8:0] l);
      @(negedge clk);
      dma_start = 1'b1;
      dma_src   = s;
      dma_len   = l;
      @(negedge clk);
      dma_start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int d0;
      bit hit;
      d0  = done_cnt;
      hit = 1'b0;
      for (int i = 0; i < bound && !hit; i++) begin
         @(negedge clk);
         if (done_cnt != d0) hit = 1'b1;
      end
      if (!hit) chk("done_timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", cpu_stall, 0);
      chk("rst_busy", dma_busy, 0);
      chk("rst_done", dma_done, 0);
      chk("rst_oam_we", oam_we, 0);
      chk("rst_oam_addr", oam_addr, 0);
      chk("rst_oam_wdata", oam_wdata, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_we", mem_we, 0);
      @(negedge clk);
      rst_n = 1'b1;

      @(negedge clk);
      cpu_addr = 16'h0401;
      cpu_mem_read = 1'b1;
      #1;
      chk("pt_re", mem_re, 1);
      chk("pt_addr", mem_addr, 16'h0401);
      @(negedge clk);
      chk("pt_rdata", mem_rdata, 16'hBBBB);
      cpu_mem_read = 1'b0;

      snap();
      start(16'h0400, 9'd4);
      wait_done(20);
      chk("b_oam0", oam[0], 16'hAAAA);
      chk("b_oam1", oam[1], 16'hBBBB);
      chk("b_oam2", oam[2], 16'hCCCC);
      chk("b_oam3", oam[3], 16'hDDDD);
      chk("b_stall", stall_cnt - s_stall, 5);
      chk("b_owe", owe_cnt - s_owe, 4);
      chk("b_done", done_cnt - s_done, 1);
      chk("b_done_t", done_cyc - start_cyc, 6);
      chk("b_rd0", rd_q[s_rd], 16'h0400);

      snap();
      start(16'h1000, 9'd300);
      wait_done(400);
      chk("c_owe", owe_cnt - s_owe, 256);
      chk("c_stall", stall_cnt - s_stall, 257);
      chk("c_done", done_cnt - s_done, 1);
      chk("c_done_t", done_cyc - start_cyc, 258);
      chk("c_nrd", rd_q.size() - s_rd, 256);
      chk("c_oam0", oam[0], pat(16'h1000));
      chk("c_oam128", oam[128], pat(16'h1080));
      chk("c_oam255", oam[255], pat(16'h10FF));

      snap();
      start(16'hFFFE, 9'd4);
      wait_done(20);
      chk("w_rd0", rd_q[s_rd], 16'hFFFE);
      chk("w_rd1", rd_q[s_rd+1], 16'hFFFF);
      chk("w_rd2", rd_q[s_rd+2], 16'h0000);
      chk("w_rd3", rd_q[s_rd+3], 16'h0001);
      chk("w_oam1", oam[1], pat(16'hFFFF));
      chk("w_oam2", oam[2], pat(16'h0000));
      chk("w_oam3", oam[3], pat(16'h0001));

      snap();
      @(negedge clk);
      cpu_addr      = 16'h0010;
      cpu_wdata     = 16'hBEEF;
      cpu_mem_write = 1'b1;
      dma_start     = 1'b1;
      dma_src       = 16'h2000;
      dma_len       = 9'd8;
      #1;
      chk("s_we", mem_we, 1);
      chk("s_addr", mem_addr, 16'h0010);
      chk("s_wdata", mem_wdata, 16'hBEEF);
      @(negedge clk);
      dma_start     = 1'b0;
      cpu_mem_write = 1'b0;
      #1;
      chk("s_dma_re", mem_re, 1);
      chk("s_dma_addr", mem_addr, 16'h2000);
      chk("s_dma_we", mem_we, 0);
      chk("s_dma_wd", mem_wdata, 0);
      chk("s_stall_on", cpu_stall, 1);
      repeat (2) @(negedge clk);
      dma_start = 1'b1;
      dma_src   = 16'h3000;
      dma_len   = 9'd3;
      @(negedge clk);
      dma_start = 1'b0;
      wait_done(30);
      chk("s_owe", owe_cnt - s_owe, 8);
      chk("s_done", done_cnt - s_done, 1);
      chk("s_done_t", done_cyc - start_cyc, 10);
      chk("s_rd7", rd_q[s_rd+7], 16'h2007);
      chk("s_oam7", oam[7], pat(16'h2007));
      chk("s_mem10", mem[16'h0010], 16'hBEEF);

      snap();
      start(16'h0400, 9'd0);
      repeat (5) @(negedge clk);
      chk("z_stall", stall_cnt - s_stall, 0);
      chk("z_owe", owe_cnt - s_owe, 0);
      chk("z_done", done_cnt - s_done, 0);
      cpu_addr     = 16'h0403;
      cpu_mem_read = 1'b1;
      #1;
      chk("z_pt_re", mem_re, 1);
      chk("z_pt_addr", mem_addr, 16'h0403);
      @(negedge clk);
      chk("z_pt_rdata", mem_rdata, 16'hDDDD);
      cpu_mem_read = 1'b0;

      snap();
      start(16'h5000, 9'd8);
      for (int i = 0; i < 20 && (owe_cnt - s_owe) < 3; i++)
         @(negedge clk);
      chk("r_owe3", owe_cnt - s_owe, 3);
      rst_n = 1'b0;
      #1;
      chk("r_oam_we", oam_we, 0);
      chk("r_oam_addr", oam_addr, 0);
      chk("r_oam_wdata", oam_wdata, 0);
      chk("r_stall", cpu_stall, 0);
      chk("r_busy", dma_busy, 0);
      chk("r_mem_re", mem_re, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("r_no_done", done_cnt - s_done, 0);

      snap();
      start(16'h0402, 9'd2);
      wait_done(20);
      chk("r2_oam0", oam[0], 16'hCCCC);
      chk("r2_oam1", oam[1], 16'hDDDD);
      chk("r2_owe", owe_cnt - s_owe, 2);
      chk("r2_stall", stall_cnt - s_stall, 3);
      chk("r2_done_t", done_cyc - start_cyc, 4);

      chk("done_stall", bad_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sequences block copies from CPU data memory into sprite OAM, and owns the single data-memory port shared by the CPU load/store path and the copy engine. When a transfer is started, it stalls the CPU pipeline and streams `dma_len` words from `dma_src` into OAM entries 0..len-1, one word per cycle. When idle, it passes CPU accesses straight through. It sits between the CPU's MEM stage (MemRead/MemWrite/OAMWrite decode) and the data-memory/OAM blocks.

## Interface
Parameters:
- `ADDR_W`, 16, data-memory address width
- `DATA_W`, 16, word width
- `OAM_ADDR_W`, 8, OAM index width (2^OAM_ADDR_W entries)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `dma_start` in 1: start request, sampled on the clock edge
- `dma_src` in ADDR_W: first source word address
- `dma_len` in OAM_ADDR_W+1: word count
- `cpu_addr` in ADDR_W: CPU memory address
- `cpu_wdata` in DATA_W: CPU store data
- `cpu_mem_read` in 1: CPU load request
- `cpu_mem_write` in 1: CPU store request
- `mem_rdata` in DATA_W: data-memory read data, one cycle after `mem_re`
- `mem_addr` out ADDR_W: data-memory address
- `mem_wdata` out DATA_W: data-memory write data
- `mem_re` out 1: data-memory read enable
- `mem_we` out 1: data-memory write enable
- `oam_addr` out OAM_ADDR_W: OAM write index
- `oam_wdata` out DATA_W: OAM write data
- `oam_we` out 1: OAM write enable
- `cpu_stall` out 1: freeze CPU pipeline
- `dma_busy` out 1: transfer in progress
- `dma_done` out 1: one-cycle completion pulse

## Operation
- FSM states:
  - IDLE: mem port = CPU signals, combinational pass-through. `oam_we`=0. `cpu_stall`=0.
  - XFER: engine owns the port. Each cycle issues `mem_re`=1 at `dma_src+rd_cnt`, then `rd_cnt`++.
    - If `rd_cnt`>0, the same cycle also writes OAM: `oam_we`=1, `oam_addr`=`rd_cnt`-1, `oam_wdata`=`mem_rdata`.
    - Goes to LAST after the read with `rd_cnt`=len-1 is issued.
  - LAST: writes the final word to OAM index len-1. No read. Next state IDLE, with `dma_done`=1 in that following cycle.
- `dma_start` in IDLE with effective len>0 latches `dma_src` and len, and moves to XFER.
- `dma_start` with `dma_len`=0 is a no-op: no stall, no `dma_done`.
- Effective len = min(`dma_len`, 2^OAM_ADDR_W).
- `dma_start` while not IDLE is ignored; latched src/len are unchanged.
- Source address arithmetic is modulo 2^ADDR_W, so it wraps past the top of memory.
- During XFER/LAST: `mem_we`=0, `mem_wdata`=0. CPU requests are not forwarded; the stalled CPU holds them.
- A CPU access in the same cycle that `dma_start` is sampled completes normally via pass-through.
- `dma_busy` = (state != IDLE). `cpu_stall` = `dma_busy`.
- Reset: asynchronous to IDLE, counters 0. A transfer in progress is abandoned with no `dma_done`.
  - Reset values: `oam_we`, `mem_re`/`mem_we` engine contribution, `cpu_stall`, `dma_busy`, `dma_done`, `oam_addr`, `oam_wdata` all 0.

## Timing
- `dma_start` sampled at edge k:
  - first `mem_re` (src) in cycle k+1
  - first `oam_we` (index 0) in cycle k+2
  - last `oam_we` (index len-1) in cycle k+len+1
- `dma_done` high for exactly cycle k+len+2. `cpu_stall` is low that same cycle.
- Stall duration is exactly len+1 cycles. Throughput is 1 word/cycle.
- Memory read latency is fixed at 1 cycle; `mem_rdata` is not registered internally.
- A new `dma_start` is accepted in the `dma_done` cycle (state is IDLE).

## Structure
- `cpu_pkg` holds:
  - `dma_state_t` enum {IDLE, XFER, LAST}
  - default widths ADDR_W/DATA_W/OAM_ADDR_W, shared with the control decoder and regfile
- Single module: FSM plus a read counter and latched src/len registers. No sub-module; the mux and counter are too small to split.

## Test plan
- Basic: src=0x0400, len=4, memory words 0x0400..0x0403 = A,B,C,D → OAM[0..3]=A,B,C,D. `cpu_stall` high 5 cycles. `dma_done` at k+6.
- Full/clamp: len=300 → exactly 256 OAM writes (index 0..255). Stall 257 cycles. Exactly one `dma_done`.
- Wrap: src=0xFFFE, len=4 → reads 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order. OAM[0..3] match.
- Simultaneous: CPU store to 0x0010 in the cycle `dma_start` is sampled → `mem_we` at 0x0010 that cycle. DMA reads start next cycle. Second `dma_start` mid-transfer ignored; the src latch is unchanged.
- len=0 → no stall, no `oam_we`, no `dma_done`. IDLE pass-through of CPU loads is verified before and after.
- Reset mid-transfer: assert `rst_n`=0 after 3 of 8 OAM writes → all outputs 0 immediately, no `dma_done`. A fresh len=2 transfer after release completes normally.
